// File: rtl/vending_change.sv
// Vending machine coin accumulator: credits N/D/Q coins, strobes open on a sale
// and pays back leftover credit one nickel per cycle.
module vending_change #(
    parameter int PRICE = 3,
    parameter int CW    = 6
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          N,
    input  logic          D,
    input  logic          Q,
    input  logic          cancel,
    output logic          open,
    output logic          nickel_out,
    output logic [CW-1:0] credit,
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        VEND,
        RETURN
    } state_t;

    localparam logic [CW-1:0] PRICE_C = CW'(PRICE);

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] credit_next;
    logic [CW-1:0] coin;
    logic [CW-1:0] sum;

    // Only the highest-value coin in a cycle counts.
    always_comb begin
        coin = '0;
        if (Q) begin
            coin = CW'(5);
        end else if (D) begin
            coin = CW'(2);
        end else if (N) begin
            coin = CW'(1);
        end
    end

    assign sum = credit + coin;

    always_comb begin
        state_next  = state;
        credit_next = credit;
        case (state)
            IDLE, COLLECT: begin
                // Cancel only matters once credit is held, and it wins over a coin.
                if (state == COLLECT && cancel) begin
                    state_next = RETURN;
                end else if (coin != '0) begin
                    if (sum >= PRICE_C) begin
                        state_next  = VEND;
                        credit_next = sum - PRICE_C;
                    end else begin
                        state_next  = COLLECT;
                        credit_next = sum;
                    end
                end
            end
            VEND: begin
                state_next = (credit != '0) ? RETURN : IDLE;
            end
            RETURN: begin
                credit_next = credit - CW'(1);
                if (credit_next == '0) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next  = IDLE;
                credit_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            credit <= '0;
        end else begin
            state  <= state_next;
            credit <= credit_next;
        end
    end

    assign open       = (state == VEND);
    assign nickel_out = (state == RETURN);
    assign busy       = (state == VEND) || (state == RETURN);

endmodule

// File: tb/tb_vending_change.sv
// Scoreboard bench for vending_change: stimulus queues expected open/nickel
// strobes, a negedge monitor pops and compares them as the DUT emits them.
module tb_vending_change;

    localparam int PRICE = 3;
    localparam int CW    = 6;

    typedef struct {
        logic          is_open;
        logic [CW-1:0] credit;
    } exp_t;

    logic          clk    = 1'b0;
    logic          reset  = 1'b0;
    logic          N      = 1'b0;
    logic          D      = 1'b0;
    logic          Q      = 1'b0;
    logic          cancel = 1'b0;
    logic          open;
    logic          nickel_out;
    logic          busy;
    logic [CW-1:0] credit;

    int   tests    = 0;
    int   failures = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    vending_change #(.PRICE(PRICE), .CW(CW)) dut (
        .clk       (clk),
        .reset     (reset),
        .N         (N),
        .D         (D),
        .Q         (Q),
        .cancel    (cancel),
        .open      (open),
        .nickel_out(nickel_out),
        .credit    (credit),
        .busy      (busy)
    );

    task automatic checkOutput(input string name, input int actual, input int expected);
        tests++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic expectStrobe(input logic is_open, input int cr);
        exp_t e;
        e.is_open = is_open;
        e.credit  = CW'(cr);
        sb.push_back(e);
    endtask

    // Drive one cycle of inputs around a single posedge, then release them.
    task automatic applyStimulus(input logic n, input logic d, input logic q, input logic c);
        @(negedge clk);
        N = n; D = d; Q = q; cancel = c;
        @(posedge clk);
        #1;
        N = 1'b0; D = 1'b0; Q = 1'b0; cancel = 1'b0;
    endtask

    task automatic checkState(input string name, input int exp_credit, input int exp_busy);
        checkOutput({name, "_credit"}, int'(credit), exp_credit);
        checkOutput({name, "_busy"}, int'(busy), exp_busy);
    endtask

    task automatic waitIdle(input string name);
        for (int i = 0; i < 30 && busy; i++) begin
            @(posedge clk);
            #1;
        end
        checkState({name, "_idle"}, 0, 0);
    endtask

    // Monitor: every strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && (open || nickel_out)) begin
            if (open && nickel_out) begin
                checkOutput("strobe_exclusive", 1, 0);
            end
            if (sb.size() == 0) begin
                checkOutput("unexpected_strobe", 1, 0);
            end else begin
                e = sb.pop_front();
                checkOutput("strobe_kind_open", int'(open), int'(e.is_open));
                checkOutput("strobe_credit", int'(credit), int'(e.credit));
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL global_timeout: got running, expected finished");
        $fatal(1, "[TB] simulation timeout");
    end

    initial begin
        #1 reset = 1'b1;
        #1;
        checkOutput("reset_open", int'(open), 0);
        checkOutput("reset_nickel", int'(nickel_out), 0);
        checkState("reset", 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Cancel with nothing held does nothing.
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkState("idle_cancel", 0, 0);

        // N, N, N: exact payment, no change.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkState("nnn_1", 1, 0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkState("nnn_2", 2, 0);
        expectStrobe(1'b1, 0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkState("nnn_3", 0, 1);
        checkOutput("nnn_open", int'(open), 1);
        waitIdle("nnn");

        // D, D: one nickel back.
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        checkState("dd_1", 2, 0);
        expectStrobe(1'b1, 1);
        expectStrobe(1'b0, 1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        checkState("dd_2", 1, 1);
        waitIdle("dd");

        // Q from IDLE: two nickels back.
        expectStrobe(1'b1, 2);
        expectStrobe(1'b0, 2);
        expectStrobe(1'b0, 1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkState("q", 2, 1);
        waitIdle("q");

        // N, then cancel with a D: dime dropped, nickel refunded.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkState("cancel_1", 1, 0);
        expectStrobe(1'b0, 1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
        checkState("cancel_2", 1, 1);
        checkOutput("cancel_open", int'(open), 0);
        waitIdle("cancel");

        // N+D together credits only the dime; a Q during VEND is ignored.
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        checkState("prio_1", 2, 0);
        expectStrobe(1'b1, 0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkState("prio_2", 0, 1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkState("vend_q_ignored", 0, 0);
        repeat (2) @(posedge clk);
        #1;
        checkState("vend_q_after", 0, 0);

        // Q, then reset in the middle of paying change.
        expectStrobe(1'b1, 2);
        expectStrobe(1'b0, 2);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        checkState("midreturn", 1, 1);
        #1 reset = 1'b1;
        #1;
        checkOutput("async_reset_open", int'(open), 0);
        checkOutput("async_reset_nickel", int'(nickel_out), 0);
        checkState("async_reset", 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        checkState("post_reset", 0, 0);

        @(negedge clk);
        checkOutput("scoreboard_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule

// File: doc/vending_change.md
VENDING_CHANGE -- requirements
Module: vending_change

Interface
REQ-001 Parameter PRICE, default 3, item price in nickel units (5-cent units); legal range 1..(2^CW - 6).
REQ-002 Parameter CW, default 6, width of the credit register in nickel units.
REQ-003 clk  input  1  single clock; all state updates on posedge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 N  input  1  nickel inserted (value 1) this cycle.
REQ-006 D  input  1  dime inserted (value 2) this cycle.
REQ-007 Q  input  1  quarter inserted (value 5) this cycle.
REQ-008 cancel  input  1  customer abort request; refund the held credit.
REQ-009 open  output  1  vend strobe, high for exactly one cycle per sale.
REQ-010 nickel_out  output  1  change strobe; each high cycle returns one nickel.
REQ-011 credit  output  CW  current held credit in nickel units.
REQ-012 busy  output  1  high while vending or returning change; coins are ignored.

Function
REQ-013 The block SHALL implement four states: IDLE (credit 0), COLLECT (0 < credit < PRICE), VEND and RETURN.
REQ-014 Outputs SHALL be Moore, decoded from registered state: open = (VEND); nickel_out = (RETURN); busy = (VEND or RETURN); credit = the credit register.
REQ-015 Coin inputs SHALL be sampled at posedge clk only in IDLE or COLLECT; in VEND or RETURN all coins SHALL be ignored (not credited).
REQ-016 If more than one coin input is high in a cycle, only the highest-value coin SHALL be credited (priority Q > D > N); the rest SHALL be discarded.
REQ-017 In IDLE or COLLECT with an accepted coin of value v: sum = credit + v; if sum >= PRICE, next state SHALL be VEND and credit SHALL become sum - PRICE; otherwise next state SHALL be COLLECT and credit SHALL become sum.
REQ-018 Latency: the coin that reaches PRICE at clock edge k SHALL cause open = 1 during the cycle after edge k, and open = 0 after edge k+1.
REQ-019 From VEND, the next state SHALL be RETURN if credit > 0, else IDLE.
REQ-020 In RETURN, credit SHALL decrement by 1 on each edge; when the decremented value is 0, the next state SHALL be IDLE.
REQ-021 The number of nickel_out cycles per RETURN visit SHALL equal the credit held on entry to RETURN.
REQ-022 cancel in COLLECT SHALL take priority over any coin in the same cycle; that coin SHALL be discarded and the next state SHALL be RETURN with credit unchanged.
REQ-023 cancel in IDLE, VEND or RETURN SHALL have no effect.
REQ-024 With no coin and no cancel, IDLE and COLLECT SHALL hold state and credit.
REQ-025 Arithmetic SHALL be unsigned CW-bit; the PRICE range in REQ-001 SHALL guarantee that sum never overflows.
REQ-026 open and nickel_out SHALL never be high in the same cycle.

Reset
REQ-027 When reset is asserted, the block SHALL asynchronously force state to IDLE, credit to 0, and open, nickel_out and busy to 0, without waiting for a clock edge.
REQ-028 Reset during VEND or RETURN SHALL forfeit any pending vend or change; no further strobes SHALL occur.
REQ-029 After reset deasserts, the first edge SHALL evaluate inputs from the IDLE state.

Verification (PRICE=3, CW=6)
REQ-030 N, N, N on three consecutive edges -> credit 1, then 2; open high for one cycle after the third edge; credit 0; no nickel_out; state returns to IDLE.
REQ-031 D, D -> credit 2, then VEND with credit 1; one nickel_out cycle; credit 0; IDLE.
REQ-032 Q from IDLE -> one open cycle with credit 2; two consecutive nickel_out cycles; IDLE.
REQ-033 N, then cancel with a D in the same cycle -> D discarded; no open; one nickel_out cycle; IDLE.
REQ-034 N and D in the same cycle from IDLE -> credit 2 (N discarded); a later Q during VEND is ignored.
REQ-035 Q, then reset asserted mid-RETURN (credit 1 remaining) -> all outputs 0 immediately; credit 0; no further nickel_out after reset deasserts.
